// File: rtl/uart_word_transceiver.sv
// Full-duplex UART that moves one DATA_W-bit word per serial frame.
// The TX and RX halves share only the clock and reset; each has its own FSM.
module uart_word_transceiver #(
    parameter int DATA_W       = 64,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tx_wr,
    input  logic [DATA_W-1:0] tx_data,
    output logic              UART_TX,
    output logic              tx_busy,
    output logic              tx_done,
    input  logic              UART_RX,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_done,
    output logic              rx_parity_err,
    output logic              rx_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY_ODD != 0);

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    tx_state_t         tx_state_reg, tx_state_next;
    logic [CNT_W-1:0]  tx_cnt_reg, tx_cnt_next;
    logic [BIT_W-1:0]  tx_bit_reg, tx_bit_next;
    logic [DATA_W-1:0] tx_shift_reg, tx_shift_next;
    logic [DATA_W-1:0] tx_shifted;
    logic              tx_par_reg, tx_par_next;
    logic              tx_line_reg, tx_line_next;
    logic              tx_bit_end;

    assign tx_shifted = tx_shift_reg >> 1;
    assign tx_bit_end = (tx_cnt_reg == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_par_reg   <= 1'b0;
            tx_line_reg  <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            tx_par_reg   <= tx_par_next;
            tx_line_reg  <= tx_line_next;
        end
    end

    // Line level for the next bit is computed here so UART_TX comes straight from a flop.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_par_next   = tx_par_reg;
        tx_line_next  = tx_line_reg;
        tx_done       = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                if (tx_wr) begin
                    tx_state_next = TX_START;
                    tx_cnt_next   = '0;
                    tx_shift_next = tx_data;
                    tx_par_next   = (^tx_data) ^ PAR_ODD;
                    tx_line_next  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                    tx_state_next = TX_DATA;
                    tx_line_next  = tx_shift_reg[0];
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_next   = '0;
                    tx_shift_next = tx_shifted;
                    if (tx_bit_reg == DATA_LAST) begin
                        tx_bit_next = '0;
                        if (PARITY_EN != 0) begin
                            tx_state_next = TX_PARITY;
                            tx_line_next  = tx_par_reg;
                        end else begin
                            tx_state_next = TX_STOP;
                            tx_line_next  = 1'b1;
                        end
                    end else begin
                        tx_bit_next  = tx_bit_reg + 1'b1;
                        tx_line_next = tx_shifted[0];
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                    tx_state_next = TX_STOP;
                    tx_line_next  = 1'b1;
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    tx_cnt_next = '0;
                    if (tx_bit_reg == STOP_LAST) begin
                        tx_state_next = TX_IDLE;
                        tx_done       = 1'b1;
                    end else begin
                        tx_bit_next = tx_bit_reg + 1'b1;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    assign UART_TX = tx_line_reg;
    assign tx_busy = (tx_state_reg != TX_IDLE);

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START_CHK, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    logic              rx_meta_reg, rx_sync_reg;
    rx_state_t         rx_state_reg, rx_state_next;
    logic [CNT_W-1:0]  rx_cnt_reg, rx_cnt_next;
    logic [BIT_W-1:0]  rx_bit_reg, rx_bit_next;
    logic [DATA_W-1:0] rx_shift_reg, rx_shift_next;
    logic              rx_par_bit_reg, rx_par_bit_next;
    logic [DATA_W-1:0] rx_data_reg, rx_data_next;
    logic              rx_done_reg, rx_done_next;
    logic              rx_perr_reg, rx_perr_next;
    logic              rx_ferr_reg, rx_ferr_next;
    logic              rx_bit_end;
    logic              rx_par_bad;

    assign rx_bit_end = (rx_cnt_reg == CNT_LAST);
    assign rx_par_bad = (PARITY_EN != 0) && (rx_par_bit_reg != ((^rx_shift_reg) ^ PAR_ODD));

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_reg    <= 1'b1;
            rx_sync_reg    <= 1'b1;
            rx_state_reg   <= RX_IDLE;
            rx_cnt_reg     <= '0;
            rx_bit_reg     <= '0;
            rx_shift_reg   <= '0;
            rx_par_bit_reg <= 1'b0;
            rx_data_reg    <= '0;
            rx_done_reg    <= 1'b0;
            rx_perr_reg    <= 1'b0;
            rx_ferr_reg    <= 1'b0;
        end else begin
            rx_meta_reg    <= UART_RX;
            rx_sync_reg    <= rx_meta_reg;
            rx_state_reg   <= rx_state_next;
            rx_cnt_reg     <= rx_cnt_next;
            rx_bit_reg     <= rx_bit_next;
            rx_shift_reg   <= rx_shift_next;
            rx_par_bit_reg <= rx_par_bit_next;
            rx_data_reg    <= rx_data_next;
            rx_done_reg    <= rx_done_next;
            rx_perr_reg    <= rx_perr_next;
            rx_ferr_reg    <= rx_ferr_next;
        end
    end

    // Start is confirmed half a bit after the edge; every later sample is one full bit on.
    always_comb begin
        rx_state_next   = rx_state_reg;
        rx_cnt_next     = rx_cnt_reg;
        rx_bit_next     = rx_bit_reg;
        rx_shift_next   = rx_shift_reg;
        rx_par_bit_next = rx_par_bit_reg;
        rx_data_next    = rx_data_reg;
        rx_done_next    = 1'b0;
        rx_perr_next    = 1'b0;
        rx_ferr_next    = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (!rx_sync_reg) begin
                    rx_state_next = RX_START_CHK;
                    rx_cnt_next   = '0;
                end
            end
            RX_START_CHK: begin
                if (rx_cnt_reg == CNT_HALF) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = DATA_W'({rx_sync_reg, rx_shift_reg} >> 1);
                    if (rx_bit_reg == DATA_LAST) begin
                        rx_bit_next   = '0;
                        rx_state_next = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_next = rx_bit_reg + 1'b1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_PARITY: begin
                if (rx_bit_end) begin
                    rx_cnt_next     = '0;
                    rx_par_bit_next = rx_sync_reg;
                    rx_state_next   = RX_STOP;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_cnt_next  = '0;
                    rx_done_next = 1'b1;
                    rx_ferr_next = !rx_sync_reg;
                    rx_perr_next = rx_par_bad;
                    if (rx_sync_reg && !rx_par_bad) begin
                        rx_data_next = rx_shift_reg;
                    end
                    // A low stop bit may be a break; hold off until the line recovers.
                    rx_state_next = rx_sync_reg ? RX_IDLE : RX_WAIT_HIGH;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync_reg) begin
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    assign rx_data       = rx_data_reg;
    assign rx_done       = rx_done_reg;
    assign rx_parity_err = rx_perr_reg;
    assign rx_frame_err  = rx_ferr_reg;

endmodule

// File: tb/tb_uart_word_transceiver.sv
// Directed bench for uart_word_transceiver: a default 64-bit instance (with
// optional TX->RX loopback) and an 8-bit even-parity, two-stop-bit instance.
module tb_uart_word_transceiver;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        loop_en;

    logic        a_tx_wr;
    logic [63:0] a_tx_data;
    logic        a_uart_tx, a_tx_busy, a_tx_done;
    logic        a_rx_line, a_uart_rx;
    logic [63:0] a_rx_data;
    logic        a_rx_done, a_perr, a_ferr;

    logic        b_tx_wr;
    logic [7:0]  b_tx_data;
    logic        b_uart_tx, b_tx_busy, b_tx_done;
    logic        b_rx_line;
    logic [7:0]  b_rx_data;
    logic        b_rx_done, b_perr, b_ferr;

    assign a_uart_rx = loop_en ? a_uart_tx : a_rx_line;

    uart_word_transceiver dut_a (
        .clock(clock), .reset(reset),
        .tx_wr(a_tx_wr), .tx_data(a_tx_data),
        .UART_TX(a_uart_tx), .tx_busy(a_tx_busy), .tx_done(a_tx_done),
        .UART_RX(a_uart_rx), .rx_data(a_rx_data), .rx_done(a_rx_done),
        .rx_parity_err(a_perr), .rx_frame_err(a_ferr)
    );

    uart_word_transceiver #(
        .DATA_W(8), .CLKS_PER_BIT(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
    ) dut_b (
        .clock(clock), .reset(reset),
        .tx_wr(b_tx_wr), .tx_data(b_tx_data),
        .UART_TX(b_uart_tx), .tx_busy(b_tx_busy), .tx_done(b_tx_done),
        .UART_RX(b_rx_line), .rx_data(b_rx_data), .rx_done(b_rx_done),
        .rx_parity_err(b_perr), .rx_frame_err(b_ferr)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int a_rxd_cnt = 0, a_txd_cnt = 0, b_rxd_cnt = 0, b_txd_cnt = 0, stray = 0;
    int a_last_cyc = 0;
    logic a_last_perr = 1'b0, a_last_ferr = 1'b0;
    logic b_last_perr = 1'b0, b_last_ferr = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitors: count done pulses, latch flags seen with them, flag orphan error pulses.
    always @(negedge clock) begin
        if (a_rx_done) begin
            a_rxd_cnt   <= a_rxd_cnt + 1;
            a_last_perr <= a_perr;
            a_last_ferr <= a_ferr;
            a_last_cyc  <= cyc;
        end
        if (b_rx_done) begin
            b_rxd_cnt   <= b_rxd_cnt + 1;
            b_last_perr <= b_perr;
            b_last_ferr <= b_ferr;
        end
        if (a_tx_done) a_txd_cnt <= a_txd_cnt + 1;
        if (b_tx_done) b_txd_cnt <= b_txd_cnt + 1;
        if (((a_perr || a_ferr) && !a_rx_done) || ((b_perr || b_ferr) && !b_rx_done))
            stray <= stray + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Frame vectors in time order: bit 0 goes on the line first.
    function automatic logic [79:0] a_bits(input logic [63:0] d, input logic stop);
        return {14'b0, stop, d, 1'b0};
    endfunction

    function automatic logic [79:0] b_bits(input logic [7:0] d, input logic par);
        return {68'b0, 2'b11, par, d, 1'b0};
    endfunction

    task automatic drive_line(input bit sel_b, input logic [79:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (sel_b) b_rx_line = bits[i];
            else       a_rx_line = bits[i];
            repeat (sel_b ? 8 : 16) @(negedge clock);
        end
    endtask

    // Sends one frame on dut_a TX and checks first/last cycle of every bit plus the handshake.
    task automatic a_tx_frame(input logic [63:0] data, input bit pre, input bit junk,
                              input bit b2b, input logic [63:0] nxt);
        logic [79:0] fb;
        fb = a_bits(data, 1'b1);
        if (!pre) begin
            a_tx_wr   = 1'b1;
            a_tx_data = data;
        end
        for (int k = 1; k <= 1057; k++) begin
            @(negedge clock);
            a_tx_wr = 1'b0;
            if (junk && k == 100) begin
                a_tx_wr   = 1'b1;
                a_tx_data = ~data;
            end
            if (k <= 1056 && ((k % 16) == 1 || (k % 16) == 0)) begin
                check($sformatf("a_tx_bit%0d", (k - 1) / 16), 64'(a_uart_tx), 64'(fb[(k - 1) / 16]));
                check("a_tx_busy", 64'(a_tx_busy), 64'd1);
            end
            if (k >= 1055) check($sformatf("a_tx_done@%0d", k), 64'(a_tx_done), 64'(k == 1056));
            if (k == 1057) begin
                check("a_tx_busy_fall", 64'(a_tx_busy), 64'd0);
                check("a_tx_idle", 64'(a_uart_tx), 64'd1);
                if (b2b) begin
                    a_tx_wr   = 1'b1;
                    a_tx_data = nxt;
                end
            end
        end
        $display("tx frame %h checked", data);
    endtask

    // Drives one 16-clock/bit frame into dut_a RX and checks the outcome and its latency.
    task automatic a_rx_frame(input logic [63:0] d, input logic stop,
                              input logic [63:0] exp_data, input logic exp_ferr);
        int c0, n0;
        c0 = cyc;
        n0 = a_rxd_cnt;
        drive_line(1'b0, a_bits(d, stop), 66);
        check("a_rx_done_cnt", 64'(a_rxd_cnt - n0), 64'd1);
        check("a_rx_latency", 64'(a_last_cyc - c0), 64'd1051);
        check("a_rx_ferr", 64'(a_last_ferr), 64'(exp_ferr));
        check("a_rx_perr", 64'(a_last_perr), 64'd0);
        check("a_rx_data", a_rx_data, exp_data);
        $display("rx frame %h stop=%0b checked", d, stop);
    endtask

    task automatic b_rx_frame(input logic [7:0] d, input logic par,
                              input logic [7:0] exp_data, input logic exp_perr);
        int n0;
        n0 = b_rxd_cnt;
        drive_line(1'b1, b_bits(d, par), 12);
        check("b_rx_done_cnt", 64'(b_rxd_cnt - n0), 64'd1);
        check("b_rx_perr", 64'(b_last_perr), 64'(exp_perr));
        check("b_rx_ferr", 64'(b_last_ferr), 64'd0);
        check("b_rx_data", 64'(b_rx_data), 64'(exp_data));
        $display("rx8 frame %h par=%0b checked", d, par);
    endtask

    logic [63:0] rx_tab [4] = '{64'hAABBCCDD11223344, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h5555AAAA5555AAAA};
    logic [11:0] bframe = 12'b1110_0000_1110; // 8'h07, even parity 1, two stops
    int n_tx0, n_rx0, n_txb;

    initial begin
        reset     = 1'b1;
        loop_en   = 1'b0;
        a_tx_wr   = 1'b0;
        a_tx_data = '0;
        a_rx_line = 1'b1;
        b_tx_wr   = 1'b0;
        b_tx_data = '0;
        b_rx_line = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        check("rst_a_tx", 64'(a_uart_tx), 64'd1);
        check("rst_a_busy", 64'(a_tx_busy), 64'd0);
        check("rst_a_txdone", 64'(a_tx_done), 64'd0);
        check("rst_a_rxdata", a_rx_data, 64'd0);
        check("rst_a_rxdone", 64'(a_rx_done), 64'd0);
        check("rst_a_errs", 64'({a_perr, a_ferr}), 64'd0);
        check("rst_b_tx", 64'(b_uart_tx), 64'd1);
        check("rst_b_rxdata", 64'(b_rx_data), 64'd0);
        repeat (5) @(negedge clock);

        // TX: busy-time write ignored, then a back-to-back frame on the busy-fall cycle.
        n_tx0 = a_txd_cnt;
        a_tx_frame(64'hFF00FF00FF00FF00, 1'b0, 1'b1, 1'b1, 64'h8000000000000001);
        a_tx_frame(64'h8000000000000001, 1'b1, 1'b0, 1'b0, 64'h0);
        check("a_tx_done_cnt", 64'(a_txd_cnt - n_tx0), 64'd2);

        // RX: four good frames with 300-cycle gaps.
        n_rx0 = a_rxd_cnt;
        for (int i = 0; i < 4; i++) begin
            a_rx_frame(rx_tab[i], 1'b1, rx_tab[i], 1'b0);
            repeat (300) @(negedge clock);
        end
        check("a_rx_4frames", 64'(a_rxd_cnt - n_rx0), 64'd4);

        // Framing error followed by a held-low line, then recovery.
        a_rx_frame(64'h123456789ABCDEF0, 1'b0, 64'h5555AAAA5555AAAA, 1'b1);
        n_rx0 = a_rxd_cnt;
        repeat (200) @(negedge clock);
        check("a_break_quiet", 64'(a_rxd_cnt - n_rx0), 64'd0);
        a_rx_line = 1'b1;
        repeat (40) @(negedge clock);
        a_rx_frame(64'h0F1E2D3C4B5A6978, 1'b1, 64'h0F1E2D3C4B5A6978, 1'b0);
        repeat (40) @(negedge clock);

        // Short low glitch must not start a frame.
        n_rx0 = a_rxd_cnt;
        a_rx_line = 1'b0;
        repeat (5) @(negedge clock);
        a_rx_line = 1'b1;
        repeat (60) @(negedge clock);
        check("a_glitch", 64'(a_rxd_cnt - n_rx0), 64'd0);
        check("a_glitch_data", a_rx_data, 64'h0F1E2D3C4B5A6978);
        $display("glitch checked");

        // 8-bit parity instance: TX of 8'h07.
        n_txb = b_txd_cnt;
        b_tx_wr   = 1'b1;
        b_tx_data = 8'h07;
        for (int k = 1; k <= 97; k++) begin
            @(negedge clock);
            b_tx_wr = 1'b0;
            if (k <= 96 && ((k % 8) == 1 || (k % 8) == 0))
                check($sformatf("b_tx_bit%0d", (k - 1) / 8), 64'(b_uart_tx), 64'(bframe[(k - 1) / 8]));
            if (k >= 95) check($sformatf("b_tx_done@%0d", k), 64'(b_tx_done), 64'(k == 96));
            if (k == 97) check("b_tx_busy_fall", 64'(b_tx_busy), 64'd0);
        end
        check("b_tx_done_cnt", 64'(b_txd_cnt - n_txb), 64'd1);
        $display("tx8 frame 07 checked");
        repeat (10) @(negedge clock);

        b_rx_frame(8'h3C, 1'b0, 8'h3C, 1'b0);
        repeat (20) @(negedge clock);
        b_rx_frame(8'h5A, 1'b1, 8'h3C, 1'b1);
        repeat (20) @(negedge clock);
        b_rx_frame(8'h01, 1'b1, 8'h01, 1'b0);
        repeat (20) @(negedge clock);

        // Reset in the middle of a TX frame and an RX frame.
        n_tx0 = a_txd_cnt;
        n_rx0 = a_rxd_cnt;
        a_tx_wr   = 1'b1;
        a_tx_data = 64'hDEADBEEF0000FFFF;
        fork
            drive_line(1'b0, a_bits(64'hFFFFFFFFFFFFFFFF, 1'b1), 66);
            begin
                @(negedge clock);
                a_tx_wr = 1'b0;
                repeat (399) @(negedge clock);
                check("a_pre_rst_tx", 64'(a_uart_tx), 64'd0);
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                check("a_rst_tx_high", 64'(a_uart_tx), 64'd1);
                check("a_rst_busy", 64'(a_tx_busy), 64'd0);
            end
        join
        repeat (200) @(negedge clock);
        check("a_rst_no_txdone", 64'(a_txd_cnt - n_tx0), 64'd0);
        check("a_rst_no_rxdone", 64'(a_rxd_cnt - n_rx0), 64'd0);
        check("a_rst_rxdata", a_rx_data, 64'd0);
        $display("mid-frame reset checked");

        // Loopback after reset: TX frame recovered by RX.
        loop_en = 1'b1;
        n_rx0 = a_rxd_cnt;
        a_tx_frame(64'h0123456789ABCDEF, 1'b0, 1'b0, 1'b0, 64'h0);
        repeat (20) @(negedge clock);
        check("a_loop_cnt", 64'(a_rxd_cnt - n_rx0), 64'd1);
        check("a_loop_data", a_rx_data, 64'h0123456789ABCDEF);
        check("a_loop_errs", 64'({a_last_perr, a_last_ferr}), 64'd0);
        loop_en = 1'b0;
        $display("loopback checked");

        check("stray_err_pulses", 64'(stray), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_word_transceiver.md
Name: uart_word_transceiver

Overview:
Parametrised full-duplex UART that sends and receives one DATA_W-bit word per serial frame. It generalises the fixed 64-bit, 16-clocks-per-bit transceiver with configurable word width, bit period, optional parity and 1 or 2 stop bits. It adds a TX busy/done handshake and RX parity and framing error reporting. It sits between the board UART pins and the word-level command logic.

Parameters:
DATA_W, 64, payload bits per frame (>=1), sent and received LSB first
CLKS_PER_BIT, 16, clock cycles per serial bit (>=4, even)
PARITY_EN, 0, 1 inserts one parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
tx_wr  in  1  request to send tx_data; accepted only when tx_busy=0
tx_data  in  DATA_W  word to transmit, sampled on the accept cycle
UART_TX  out  1  serial output, idles high
tx_busy  out  1  high from the accept cycle until the frame ends
tx_done  out  1  one-cycle pulse at the end of the last stop bit
UART_RX  in  1  asynchronous serial input, idles high
rx_data  out  DATA_W  last word received without error; holds its value between frames
rx_done  out  1  one-cycle pulse for every completed frame
rx_parity_err  out  1  one-cycle pulse coincident with rx_done; received parity is wrong
rx_frame_err  out  1  one-cycle pulse coincident with rx_done; stop bit sampled as 0

Behaviour:
- Reset: UART_TX=1, tx_busy=0, tx_done=0, rx_data=0, rx_done=0, both error flags 0. Both FSMs go to IDLE. Reset mid-frame aborts the frame immediately; no done pulse is generated.
- Frame: start bit (0), DATA_W data bits LSB first, optional parity bit, STOP_BITS stop bits (1). Each bit lasts exactly CLKS_PER_BIT cycles. Frame length F = (1 + DATA_W + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Parity: even parity bit = XOR of the data bits. Odd parity bit = inverted XOR.
- TX FSM: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE. A bit counter and a bit-period counter are used.
  - On tx_wr=1 in IDLE: latch tx_data into a shift register and set tx_busy=1 in the next cycle.
  - UART_TX goes 0 on the cycle after accept and is registered.
  - tx_done pulses for 1 cycle on the final cycle of the last stop bit. tx_busy drops the cycle after that.
  - tx_wr while tx_busy=1 is ignored; the frame in flight is unaffected.
  - A tx_wr in the cycle tx_busy falls is accepted. Frames can run back-to-back with no extra idle bit.
- RX front end: two-flop synchroniser on UART_RX, giving 2 cycles of latency. All RX decisions use the synchronised bit.
- RX FSM: IDLE -> START_CHK -> DATA -> PARITY (if enabled) -> STOP -> IDLE, plus WAIT_HIGH.
  - IDLE: a synchronised 0 starts the bit-period counter.
  - START_CHK: at mid-bit (CLKS_PER_BIT/2 cycles after detect), a 1 is treated as a glitch and the FSM returns to IDLE with no pulse. A 0 moves the FSM to DATA.
  - Each later bit is sampled exactly CLKS_PER_BIT cycles after the previous sample (mid-bit) and shifted in LSB first.
  - The first stop bit is sampled at its mid-bit. rx_done pulses on the next cycle, without waiting for the end of the stop bit. With STOP_BITS=2, only the first stop bit is checked.
  - rx_data is updated on the rx_done cycle only if neither error is set. On error, rx_data keeps its previous value and the relevant error flag pulses with rx_done.
  - After a framing error (stop bit = 0, e.g. a line break), go to WAIT_HIGH. Stay there until the synchronised line reads 1, then go to IDLE, so a held-low line cannot generate repeated frames.
  - After a good stop bit, go straight to IDLE; a start edge in the following half-bit is detected.
- TX and RX are fully independent. Simultaneous activity and an external TX-to-RX loopback must both work.

Test Plan:
- Defaults, tx_wr with tx_data=64'hFF00FF00FF00FF00 -> UART_TX low for 16 cycles, then the data bits LSB first (first 8 bits 0, next 8 bits 1, 16 cycles each), then high. tx_done pulses 1056 cycles after accept; tx_busy is high throughout.
- Defaults, UART_RX driven with a 16-cycle/bit frame of 64'hAABBCCDD11223344 and a good stop bit -> rx_done pulses once, rx_data=64'hAABBCCDD11223344, no error flags. Repeat 4 frames with 300-cycle gaps -> 4 rx_done pulses.
- Stop bit driven 0 -> rx_frame_err pulses with rx_done and rx_data is unchanged. With the line held low for 200 cycles there are no further rx_done pulses. The line then returns high and the next good frame is received.
- PARITY_EN=1, PARITY_ODD=0, DATA_W=8: TX of 8'h07 -> parity bit 1. An RX frame with a flipped parity bit -> rx_parity_err=1 and rx_data is held.
- 5-cycle low glitch on UART_RX -> no rx_done. tx_wr pulsed while busy -> exactly one frame, still carrying the first data. Back-to-back tx_wr on the tx_busy falling cycle -> next start bit immediately follows the stop bit.
- reset asserted mid-TX and mid-RX -> UART_TX=1 next cycle, no done pulses. A frame sent after reset is correct; UART_TX looped to UART_RX recovers the sent word.
